// File: rtl/dct_sched_pkg.sv
// Shared types and constants for the DCT stripe scheduler.
package dct_sched_pkg;

  localparam int BLOCK_SIZE = 8;

  typedef enum logic {IDLE = 1'b0, PASS = 1'b1} sched_state_t;

  function automatic int comp_id_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dct_tag_fifo.sv
// Component-tag FIFO: one entry per granted stripe, head valid the cycle after push.
// A pop frees a slot for a same-cycle push; pops on empty are ignored. DEPTH is a power of two >= 2.
module dct_tag_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_vld,
  input  logic [WIDTH-1:0] i_wr_dat,
  input  logic             i_rd_vld,
  output logic [WIDTH-1:0] o_head_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
  assign o_empty    = (r_count == '0);
  assign w_rd       = i_rd_vld && !o_empty;
  assign w_wr       = i_wr_vld && (!o_full || w_rd);
  // Empty head reads as zero so the tag output is clean out of reset.
  assign o_head_dat = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_rd)      r_count <= r_count + (PTR_W+1)'(1);
      else if (w_rd && !w_wr) r_count <= r_count - (PTR_W+1)'(1);
    end
  end

endmodule

// File: rtl/dct_stripe_sched.sv
// Round-robin stripe scheduler sharing one DCT core; grant 1 cycle after request, zero-latency data mux.
// A granted stream holds the core for BLOCK_LINES lines; output stripes are labelled from the tag FIFO.
module dct_stripe_sched
  import dct_sched_pkg::*;
#(
  parameter int PX_WIDTH       = 8,
  parameter int PX_TDATA_WIDTH = ((PX_WIDTH + 7) / 8) * 8,
  parameter int FRAME_RES_X    = 1920,
  parameter int COMP_NUM       = 3,
  parameter int BLOCK_LINES    = BLOCK_SIZE,
  parameter int TAG_DEPTH      = 4,
  parameter int COMP_ID_WIDTH  = comp_id_w(COMP_NUM)
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [COMP_NUM*PX_TDATA_WIDTH-1:0] comp_i_tdata,
  input  logic [COMP_NUM-1:0]                comp_i_tvalid,
  output logic [COMP_NUM-1:0]                comp_i_tready,
  input  logic [COMP_NUM-1:0]                comp_i_tlast,
  input  logic [COMP_NUM-1:0]                comp_i_tuser,
  output logic [PX_TDATA_WIDTH-1:0]          video_o_tdata,
  output logic                               video_o_tvalid,
  input  logic                               video_o_tready,
  output logic                               video_o_tlast,
  output logic                               video_o_tuser,
  input  logic                               dct_mon_tvalid,
  input  logic                               dct_mon_tready,
  output logic [COMP_ID_WIDTH-1:0]           comp_id_o,
  output logic                               comp_id_valid_o,
  output logic                               tag_err_o
);

  localparam int COEF_N = FRAME_RES_X * BLOCK_LINES;
  localparam int COEF_W = $clog2(COEF_N);
  localparam int LINE_W = $clog2(BLOCK_LINES + 1);

  sched_state_t             r_state;
  logic [COMP_ID_WIDTH-1:0] r_sel;
  logic [COMP_ID_WIDTH-1:0] r_last_grant;
  logic [LINE_W-1:0]        r_line_cnt;
  logic [COEF_W-1:0]        r_coef_cnt;
  logic                     r_tag_err;

  logic [COMP_ID_WIDTH-1:0] w_pick;
  logic [COMP_ID_WIDTH:0]   w_scan;
  logic                     w_any_req;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_full;
  logic                     w_empty;
  logic [COMP_ID_WIDTH-1:0] w_head;
  logic                     w_sel_last;
  logic                     w_mon_beat;
  logic                     w_coef_wrap;

  // Scan farthest-first so the requester nearest after last_grant wins.
  always_comb begin
    w_pick    = r_last_grant;
    w_any_req = 1'b0;
    w_scan    = '0;
    for (int i = COMP_NUM; i >= 1; i--) begin
      w_scan = {1'b0, r_last_grant} + (COMP_ID_WIDTH+1)'(i);
      if (w_scan >= (COMP_ID_WIDTH+1)'(COMP_NUM)) w_scan = w_scan - (COMP_ID_WIDTH+1)'(COMP_NUM);
      if (comp_i_tvalid[w_scan]) begin
        w_pick    = w_scan[COMP_ID_WIDTH-1:0];
        w_any_req = 1'b1;
      end
    end
  end

  assign w_push     = (r_state == IDLE) && !w_full && w_any_req;
  assign w_sel_last = (r_state == PASS) && comp_i_tvalid[r_sel] && video_o_tready && comp_i_tlast[r_sel];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_sel        <= '0;
      r_last_grant <= COMP_ID_WIDTH'(COMP_NUM - 1);
      r_line_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_push) begin
            r_sel   <= w_pick;
            r_state <= PASS;
          end
        end
        PASS: begin
          if (w_sel_last) begin
            if (r_line_cnt == LINE_W'(BLOCK_LINES - 1)) begin
              r_line_cnt   <= '0;
              r_last_grant <= r_sel;
              r_state      <= IDLE;
            end else begin
              r_line_cnt <= r_line_cnt + LINE_W'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    comp_i_tready  = '0;
    video_o_tdata  = '0;
    video_o_tvalid = 1'b0;
    video_o_tlast  = 1'b0;
    video_o_tuser  = 1'b0;
    if (r_state == PASS) begin
      comp_i_tready[r_sel] = video_o_tready;
      video_o_tdata        = comp_i_tdata[r_sel*PX_TDATA_WIDTH +: PX_TDATA_WIDTH];
      video_o_tvalid       = comp_i_tvalid[r_sel];
      video_o_tlast        = comp_i_tlast[r_sel];
      video_o_tuser        = comp_i_tuser[r_sel];
    end
  end

  assign w_mon_beat  = dct_mon_tvalid && dct_mon_tready;
  assign w_coef_wrap = (r_coef_cnt == COEF_W'(COEF_N - 1));
  assign w_pop       = w_mon_beat && w_coef_wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_coef_cnt <= '0;
      r_tag_err  <= 1'b0;
    end else begin
      if (w_mon_beat) r_coef_cnt <= w_coef_wrap ? '0 : r_coef_cnt + COEF_W'(1);
      if (w_mon_beat && w_empty) r_tag_err <= 1'b1;
    end
  end

  dct_tag_fifo #(
    .WIDTH (COMP_ID_WIDTH),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_wr_vld   (w_push),
    .i_wr_dat   (w_pick),
    .i_rd_vld   (w_pop),
    .o_head_dat (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  assign comp_id_o       = w_head;
  assign comp_id_valid_o = !w_empty;
  assign tag_err_o       = r_tag_err;

endmodule

// File: tb/tb_dct_stripe_sched.sv
// Directed bench for dct_stripe_sched with FRAME_RES_X=16, COMP_NUM=3, TAG_DEPTH=4.
module tb_dct_stripe_sched;

  localparam int NC     = 3;
  localparam int XRES   = 16;
  localparam int STRIPE = XRES * 8;
  localparam int BIG    = 100000;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NC*8-1:0] comp_i_tdata;
  logic [NC-1:0]   comp_i_tvalid;
  logic [NC-1:0]   comp_i_tready;
  logic [NC-1:0]   comp_i_tlast;
  logic [NC-1:0]   comp_i_tuser;
  logic [7:0]      video_o_tdata;
  logic            video_o_tvalid;
  logic            video_o_tready;
  logic            video_o_tlast;
  logic            video_o_tuser;
  logic            dct_mon_tvalid;
  logic            dct_mon_tready;
  logic [1:0]      comp_id_o;
  logic            comp_id_valid_o;
  logic            tag_err_o;

  always #5 clk_i = ~clk_i;

  dct_stripe_sched #(
    .PX_WIDTH    (8),
    .FRAME_RES_X (XRES),
    .COMP_NUM    (NC),
    .BLOCK_LINES (8),
    .TAG_DEPTH   (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .comp_i_tdata    (comp_i_tdata),
    .comp_i_tvalid   (comp_i_tvalid),
    .comp_i_tready   (comp_i_tready),
    .comp_i_tlast    (comp_i_tlast),
    .comp_i_tuser    (comp_i_tuser),
    .video_o_tdata   (video_o_tdata),
    .video_o_tvalid  (video_o_tvalid),
    .video_o_tready  (video_o_tready),
    .video_o_tlast   (video_o_tlast),
    .video_o_tuser   (video_o_tuser),
    .dct_mon_tvalid  (dct_mon_tvalid),
    .dct_mon_tready  (dct_mon_tready),
    .comp_id_o       (comp_id_o),
    .comp_id_valid_o (comp_id_valid_o),
    .tag_err_o       (tag_err_o)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int px[NC];
  int src_left[NC];
  bit src_rand, rdy_rand, mon_rand, mon_follow;
  int mon_left, mon_credit;
  int grant_q[$];
  int gap_q[$];
  int stripe_beats, stripe_comp, last_end_cyc, n_stripes;
  int mon_cnt, mon_stripe, n_vbeats, n_vlast;
  logic [NC-1:0] rdy_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_dat(input int k, input int idx);
    logic [1:0] kk;
    logic [5:0] ii;
    kk = k[1:0];
    ii = idx[5:0];
    return {kk, ii};
  endfunction

  // A source keeps tvalid high until its beat is taken.
  task automatic refresh(input logic [NC-1:0] hs);
    for (int k = 0; k < NC; k++) begin
      if (!(comp_i_tvalid[k] === 1'b1 && !hs[k] && src_left[k] > 0))
        comp_i_tvalid[k] = (src_left[k] > 0) && (!src_rand || $urandom_range(0, 3) != 0);
      comp_i_tdata[k*8 +: 8] = exp_dat(k, px[k]);
      comp_i_tlast[k] = ((px[k] % XRES) == XRES - 1);
      comp_i_tuser[k] = (px[k] == 0);
    end
    video_o_tready = !rdy_rand || ($urandom_range(0, 3) != 0);
    dct_mon_tvalid = (mon_follow && mon_credit > 0) || (mon_left > 0);
    dct_mon_tready = !mon_rand || ($urandom_range(0, 2) != 0);
  endtask

  task automatic tick();
    logic [NC-1:0] hs;
    logic vhs, mhs;
    int k;
    @(negedge clk_i);
    hs  = comp_i_tvalid & comp_i_tready;
    vhs = video_o_tvalid && video_o_tready;
    mhs = dct_mon_tvalid && dct_mon_tready;
    rdy_seen |= comp_i_tready;
    if (vhs || hs != '0) check("hs_onehot", $countones(hs), vhs ? 1 : 0);
    if (vhs && $countones(hs) == 1) begin
      k = 0;
      for (int j = 0; j < NC; j++) if (hs[j]) k = j;
      check("pix", {video_o_tdata, video_o_tlast, video_o_tuser},
            {exp_dat(k, px[k]), ((px[k] % XRES) == XRES - 1), (px[k] == 0)});
      n_vbeats++;
      if (video_o_tlast) n_vlast++;
      if (mon_follow) mon_credit++;
      if (stripe_beats == 0) begin
        grant_q.push_back(k);
        if (n_stripes > 0) gap_q.push_back(cyc - last_end_cyc);
        stripe_comp = k;
      end else begin
        check("no_preempt", k, stripe_comp);
      end
      stripe_beats++;
      if (stripe_beats == STRIPE) begin
        stripe_beats = 0;
        n_stripes++;
        last_end_cyc = cyc;
      end
    end
    if (mhs) begin
      if (mon_stripe < grant_q.size())
        check("comp_id", {comp_id_valid_o, comp_id_o}, {1'b1, 2'(grant_q[mon_stripe])});
      if (mon_follow) mon_credit--;
      else if (mon_left > 0) mon_left--;
      mon_cnt++;
      if (mon_cnt == STRIPE) begin
        mon_cnt = 0;
        mon_stripe++;
      end
    end
    @(posedge clk_i);
    #1;
    cyc++;
    for (int j = 0; j < NC; j++) begin
      if (hs[j]) begin
        px[j]++;
        if (src_left[j] > 0) src_left[j]--;
      end
    end
    refresh(hs);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    src_left = '{0, 0, 0};
    px = '{0, 0, 0};
    src_rand = 0; rdy_rand = 0; mon_rand = 0; mon_follow = 0;
    mon_left = 0; mon_credit = 0;
    refresh('0);
    tick();
    rst_i = 1'b0;
    grant_q.delete();
    gap_q.delete();
    stripe_beats = 0; n_stripes = 0; mon_cnt = 0; mon_stripe = 0;
    n_vbeats = 0; n_vlast = 0; rdy_seen = '0;
  endtask

  task automatic run_stripes(input int n, input int budget, input string tag);
    int t = 0;
    while (n_stripes < n && t < budget) begin
      tick();
      t++;
    end
    check(tag, n_stripes >= n, 1);
  endtask

  task automatic run_grants(input int n, input int budget, input string tag);
    int t = 0;
    while (grant_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    check(tag, grant_q.size() >= n, 1);
  endtask

  function automatic int grant_at(input int i);
    return (i < grant_q.size()) ? grant_q[i] : -1;
  endfunction

  initial begin
    rst_i = 1'b1;
    comp_i_tvalid = '0;
    do_reset();
    check("rst_tready", comp_i_tready, 0);
    check("rst_vvalid", video_o_tvalid, 0);
    check("rst_idv", comp_id_valid_o, 0);
    check("rst_id", comp_id_o, 0);
    check("rst_err", tag_err_o, 0);

    // Single stream, exactly one stripe offered.
    src_left[1] = STRIPE;
    refresh('0);
    run_stripes(1, 400, "t1_timeout");
    check("t1_idle_after", comp_i_tready, 0);
    check("t1_fifo", {comp_id_valid_o, comp_id_o}, 3'b101);
    repeat (4) tick();
    check("t1_beats", n_vbeats, STRIPE);
    check("t1_lasts", n_vlast, 8);
    check("t1_rdy_seen", rdy_seen, 3'b010);

    // All streams valid, monitor follows the data path.
    do_reset();
    mon_follow = 1;
    src_left = '{BIG, BIG, BIG};
    refresh('0);
    run_stripes(6, 1200, "t2_timeout");
    for (int i = 0; i < 6; i++) check("t2_order", grant_at(i), i % 3);
    for (int i = 0; i < 5; i++) check("t2_gap", (i < gap_q.size()) ? gap_q[i] : -1, 2);
    check("t2_err", tag_err_o, 0);

    // Stream 2 arrives mid-stripe of stream 0.
    do_reset();
    mon_follow = 1;
    src_left[0] = BIG;
    refresh('0);
    repeat (40) tick();
    src_left[2] = BIG;
    refresh('0);
    run_stripes(3, 800, "t3_timeout");
    check("t3_g0", grant_at(0), 0);
    check("t3_g1", grant_at(1), 2);
    check("t3_g2", grant_at(2), 0);

    // Monitor idle: tag FIFO fills after four stripes.
    do_reset();
    src_left = '{BIG, BIG, BIG};
    refresh('0);
    run_stripes(4, 800, "t4_timeout");
    repeat (20) tick();
    check("t4_hold_rdy", comp_i_tready, 0);
    check("t4_hold_vld", video_o_tvalid, 0);
    check("t4_grants", grant_q.size(), 4);
    check("t4_order3", grant_at(3), 0);
    check("t4_head", {comp_id_valid_o, comp_id_o}, 3'b100);
    mon_left = STRIPE;
    refresh('0);
    run_grants(5, 400, "t4_timeout5");
    check("t4_id_after", {comp_id_valid_o, comp_id_o}, 3'b101);
    check("t4_g5", grant_at(4), 1);
    check("t4_err", tag_err_o, 0);

    // Monitor beats with nothing granted.
    do_reset();
    mon_left = STRIPE;
    refresh('0);
    repeat (STRIPE + 4) tick();
    check("t5_err_set", tag_err_o, 1);
    check("t5_idv", comp_id_valid_o, 0);
    repeat (10) tick();
    check("t5_err_sticky", tag_err_o, 1);
    do_reset();
    check("t5_err_clr", tag_err_o, 0);
    check("t5_idv_clr", comp_id_valid_o, 0);
    src_left = '{BIG, BIG, BIG};
    refresh('0);
    run_grants(1, 20, "t5_timeout");
    check("t5_first", grant_at(0), 0);

    // Random backpressure on sources, DCT input and monitor.
    do_reset();
    src_rand = 1; rdy_rand = 1; mon_rand = 1; mon_follow = 1;
    src_left = '{BIG, BIG, BIG};
    refresh('0);
    run_stripes(12, 9000, "t6_timeout");
    check("t6_err", tag_err_o, 0);
    check("t6_mon_progress", mon_stripe >= 8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
